// File: rtl/jtag_scan_sequencer_if.sv
// Command/response handshake bundle between a scan host and the JTAG sequencer.
interface jtag_scan_sequencer_if #(
    parameter int IR_WIDTH = 2,
    parameter int DATA_REG = 5
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_skip_ir;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DATA_REG-1:0] cmd_dr;
    logic                rsp_valid;
    logic [DATA_REG-1:0] rsp_dr;
    logic                busy;

    modport master (
        output cmd_valid, cmd_skip_ir, cmd_ir, cmd_dr,
        input  cmd_ready, rsp_valid, rsp_dr, busy
    );

    modport slave (
        input  cmd_valid, cmd_skip_ir, cmd_ir, cmd_dr,
        output cmd_ready, rsp_valid, rsp_dr, busy
    );
endinterface

// File: rtl/jtag_scan_sequencer.sv
// Drives TMS/TDI through an IR scan (optional) and a DR scan per command,
// capturing the DR TDO bits into the response.
module jtag_scan_sequencer #(
    parameter int IR_WIDTH = 2,
    parameter int DATA_REG = 5
) (
    input  logic                        tclk,
    input  logic                        trst,
    jtag_scan_sequencer_if.slave        bus,
    output logic                        tms,
    output logic                        tdi,
    input  logic                        tdo
);
    localparam int MAX_LEN = (IR_WIDTH > DATA_REG) ? IR_WIDTH : DATA_REG;
    localparam int SW = $clog2(MAX_LEN) + 1;
    localparam logic [SW-1:0] IR_LAST = SW'(IR_WIDTH - 1);
    localparam logic [SW-1:0] DR_LAST = SW'(DATA_REG - 1);

    typedef enum logic [3:0] {
        INIT_TLR, INIT_RTI, IDLE,
        IR_HDR, IR_SHIFT, IR_TAIL,
        DR_HDR, DR_SHIFT, DR_TAIL,
        DONE
    } state_t;

    state_t              state, nstate;
    logic [2:0]          step, nstep;
    logic [SW-1:0]       sc, nsc;
    logic [SW-1:0]       cap_idx;
    logic                cap_en;
    logic [IR_WIDTH-1:0] ir_q, ir_sel;
    logic [DATA_REG-1:0] dr_q, dr_sel;
    logic                accept, ntms, ntdi;

    assign accept   = bus.cmd_valid && bus.cmd_ready;
    assign bus.busy = ~bus.cmd_ready;
    assign ir_sel   = ir_q >> nsc;
    assign dr_sel   = dr_q >> nsc;

    // step times the fixed TMS walks; sc indexes shift bits
    always_comb begin
        nstate = state;
        nstep  = step + 3'd1;
        nsc    = '0;
        unique case (state)
            INIT_TLR: if (step == 3'd4) begin nstate = INIT_RTI; nstep = '0; end
            INIT_RTI: begin nstate = IDLE; nstep = '0; end
            IDLE: begin
                nstep = '0;
                if (accept) nstate = bus.cmd_skip_ir ? DR_HDR : IR_HDR;
            end
            IR_HDR:   if (step == 3'd3) begin nstate = IR_SHIFT; nstep = '0; end
            IR_SHIFT: begin
                nstep = '0;
                if (sc == IR_LAST) nstate = IR_TAIL;
                else nsc = sc + 1'b1;
            end
            IR_TAIL:  if (step == 3'd1) begin nstate = DR_HDR; nstep = '0; end
            DR_HDR:   if (step == 3'd2) begin nstate = DR_SHIFT; nstep = '0; end
            DR_SHIFT: begin
                nstep = '0;
                if (sc == DR_LAST) nstate = DR_TAIL;
                else nsc = sc + 1'b1;
            end
            DR_TAIL:  if (step == 3'd1) begin nstate = DONE; nstep = '0; end
            DONE:     begin nstate = IDLE; nstep = '0; end
            default:  begin nstate = INIT_TLR; nstep = '0; end
        endcase
    end

    // pin values for the cycle about to start, so tms/tdi come from flops
    always_comb begin
        ntms = 1'b0;
        ntdi = 1'b0;
        unique case (nstate)
            INIT_TLR: ntms = 1'b1;
            IR_HDR:   ntms = (nstep < 3'd2);
            IR_SHIFT: begin ntms = (nsc == IR_LAST); ntdi = ir_sel[0]; end
            IR_TAIL, DR_HDR, DR_TAIL: ntms = (nstep == 3'd0);
            DR_SHIFT: begin ntms = (nsc == DR_LAST); ntdi = dr_sel[0]; end
            default:  ntms = 1'b0;
        endcase
    end

    always_ff @(posedge tclk) begin
        if (trst) begin
            state         <= INIT_TLR;
            step          <= '0;
            sc            <= '0;
            tms           <= 1'b1;
            tdi           <= 1'b0;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_dr    <= '0;
            cap_en        <= 1'b0;
            cap_idx       <= '0;
            ir_q          <= '0;
            dr_q          <= '0;
        end else begin
            state         <= nstate;
            step          <= nstep;
            sc            <= nsc;
            tms           <= ntms;
            tdi           <= ntdi;
            bus.cmd_ready <= (nstate == IDLE);
            bus.rsp_valid <= (nstate == DONE);
            // target TDO lags its shift cycle by one tclk
            cap_en        <= (state == DR_SHIFT);
            cap_idx       <= sc;
            if (accept) begin
                ir_q <= bus.cmd_ir;
                dr_q <= bus.cmd_dr;
            end
            if (cap_en) begin
                for (int i = 0; i < DATA_REG; i++) begin
                    if (cap_idx == SW'(i)) bus.rsp_dr[i] <= tdo;
                end
            end
        end
    end
endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Scoreboard bench for jtag_scan_sequencer with a loopback target (tdo = tdi
// delayed one tclk).
module tb_jtag_scan_sequencer;
    logic tclk = 1'b0;
    logic trst = 1'b1;
    logic tms, tdi;
    logic tdo = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [4:0] dr;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    logic [0:7]  ir_tms_pat = 8'b11000110;
    logic [0:10] dr_tms_pat = 11'b10000001100;

    jtag_scan_sequencer_if #(.IR_WIDTH(2), .DATA_REG(5)) bus ();

    jtag_scan_sequencer #(.IR_WIDTH(2), .DATA_REG(5)) dut (
        .tclk (tclk),
        .trst (trst),
        .bus  (bus),
        .tms  (tms),
        .tdi  (tdi),
        .tdo  (tdo)
    );

    always #5 tclk = ~tclk;
    always @(posedge tclk) cyc <= cyc + 1;
    always @(posedge tclk) tdo <= tdi;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every response pops one expectation
    always @(negedge tclk) begin
        if (!trst && bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_dr %0h expected none",
                         bus.rsp_dr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_dr", 32'(bus.rsp_dr), 32'(e.dr));
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Entered on the negedge right after a reset edge, trst already low
    task automatic init_check();
        chk("rst_tms", 32'(tms), 32'd1);
        chk("rst_tdi", 32'(tdi), 32'd0);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_dr", 32'(bus.rsp_dr), 32'd0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge tclk);
            chk("init_tms", 32'(tms), 32'(k < 5));
            chk("init_ready", 32'(bus.cmd_ready), 32'd0);
        end
        @(negedge tclk);
        chk("init_ready7", 32'(bus.cmd_ready), 32'd1);
        chk("init_busy7", 32'(bus.busy), 32'd0);
        chk("idle_tms", 32'(tms), 32'd0);
    endtask

    task automatic wait_ready(output bit ok);
        int w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 50) begin
            @(negedge tclk);
            w++;
        end
        ok = (bus.cmd_ready === 1'b1);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got cmd_ready %b expected 1", bus.cmd_ready);
        end
    endtask

    task automatic send(input logic [1:0] ir, input logic [4:0] dr,
                        input logic skip);
        logic [0:18] et, ed;
        int   n, base;
        bit   ok;
        wait_ready(ok);
        if (!ok) return;
        bus.cmd_valid   = 1'b1;
        bus.cmd_ir      = ir;
        bus.cmd_dr      = dr;
        bus.cmd_skip_ir = skip;
        @(posedge tclk);
        @(negedge tclk);
        bus.cmd_valid   = 1'b0;
        bus.cmd_ir      = ~ir;
        bus.cmd_dr      = ~dr;
        bus.cmd_skip_ir = ~skip;
        n    = skip ? 11 : 19;
        base = skip ? 0 : 8;
        sb.push_back('{dr: dr, cyc: cyc + n - 1});
        et = '0;
        ed = '0;
        if (!skip) begin
            for (int i = 0; i < 8; i++) et[i] = ir_tms_pat[i];
            ed[4] = ir[0];
            ed[5] = ir[1];
        end
        for (int i = 0; i < 11; i++) et[base + i] = dr_tms_pat[i];
        for (int i = 0; i < 5; i++) ed[base + 3 + i] = dr[i];
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge tclk);
            chk($sformatf("tms[%0d]", k), 32'(tms), 32'(et[k]));
            chk($sformatf("tdi[%0d]", k), 32'(tdi), 32'(ed[k]));
        end
    endtask

    initial begin
        bit ok;
        bus.cmd_valid   = 1'b0;
        bus.cmd_skip_ir = 1'b0;
        bus.cmd_ir      = '0;
        bus.cmd_dr      = '0;
        repeat (3) @(posedge tclk);
        @(negedge tclk);
        trst = 1'b0;
        init_check();

        send(2'b10, 5'b00000, 1'b0);
        send(2'b01, 5'b01101, 1'b0);
        send(2'b11, 5'b10110, 1'b1);

        // valid held high: one acceptance per IDLE visit
        wait_ready(ok);
        bus.cmd_valid   = 1'b1;
        bus.cmd_skip_ir = 1'b1;
        bus.cmd_dr      = 5'b00111;
        @(posedge tclk);
        @(negedge tclk);
        sb.push_back('{dr: 5'b00111, cyc: cyc + 10});
        bus.cmd_dr = 5'b11001;
        for (int k = 0; k < 11; k++) begin
            if (k > 0) @(negedge tclk);
            chk("held_busy", 32'(bus.cmd_ready), 32'd0);
        end
        @(negedge tclk);
        chk("held_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge tclk);
        @(negedge tclk);
        sb.push_back('{dr: 5'b11001, cyc: cyc + 10});
        bus.cmd_valid = 1'b0;
        chk("held_second_busy", 32'(bus.cmd_ready), 32'd0);
        repeat (10) @(negedge tclk);

        // reset during DR shift abandons the scan
        wait_ready(ok);
        bus.cmd_valid   = 1'b1;
        bus.cmd_skip_ir = 1'b1;
        bus.cmd_dr      = 5'b11111;
        @(posedge tclk);
        @(negedge tclk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge tclk);
        trst = 1'b1;
        @(posedge tclk);
        @(negedge tclk);
        trst = 1'b0;
        init_check();
        repeat (15) @(negedge tclk);
        chk("no_rsp_after_reset", 32'(bus.rsp_dr), 32'd0);

        send(2'b00, 5'b01010, 1'b1);
        repeat (5) @(negedge tclk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/jtag_scan_sequencer.md
JTAG_SCAN_SEQUENCER -- requirements
Module: jtag_scan_sequencer

Interface
REQ-001 The module SHALL have parameter IR_WIDTH, default 2, giving the target instruction register length in bits.
REQ-002 The module SHALL have parameter DATA_REG, default 5, giving the target data register length in bits.
REQ-003 Port tclk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 Port trst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 Port cmd_valid  input  1  SHALL indicate that a scan command is presented.
REQ-006 Port cmd_ready  output  1  SHALL indicate that the sequencer can accept a command.
REQ-007 Port cmd_skip_ir  input  1  SHALL request a DR-only scan when 1, with no IR scan.
REQ-008 Port cmd_ir  input  IR_WIDTH  SHALL carry the instruction to load.
REQ-009 Port cmd_dr  input  DATA_REG  SHALL carry the data to shift in.
REQ-010 Port tms  output  1  SHALL drive the target TMS.
REQ-011 Port tdi  output  1  SHALL drive the target TDI.
REQ-012 Port tdo  input  1  SHALL carry the target TDO, which is registered in the target and valid one tclk after each target shift cycle.
REQ-013 Port rsp_valid  output  1  SHALL be a one-cycle pulse marking a completed scan.
REQ-014 Port rsp_dr  output  DATA_REG  SHALL carry the captured TDO bits of the last DR scan.
REQ-015 Port busy  output  1  SHALL be high whenever cmd_ready is low.

Function
REQ-016 The FSM SHALL use these states: INIT_TLR, INIT_RTI, IDLE, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL, DONE.
REQ-017 tms and tdi SHALL be registered outputs; a "drive cycle" is one tclk period in which they hold a value.
REQ-018 INIT_TLR SHALL drive tms=1 for 5 cycles, then INIT_RTI SHALL drive tms=0 for 1 cycle, then the FSM SHALL enter IDLE; this leaves the target in Run-Test/Idle.
REQ-019 In IDLE: cmd_ready=1, tms=0, tdi=0.
REQ-020 A command SHALL be accepted on the edge where cmd_valid and cmd_ready are both 1; cmd_ir, cmd_dr and cmd_skip_ir SHALL be latched on that edge, and cmd_ready SHALL drop in the next cycle.
REQ-021 The first drive cycle SHALL be the cycle immediately after acceptance; it starts in IR_HDR, or in DR_HDR when cmd_skip_ir=1.
REQ-022 IR_HDR SHALL drive tms = 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
REQ-023 IR_SHIFT SHALL last IR_WIDTH cycles, with tdi = latched IR bit i (LSB first) and tms=0, except tms=1 on the last bit.
REQ-024 IR_TAIL SHALL drive tms = 1,0 (Update-IR, Run-Test/Idle), then go to DR_HDR.
REQ-025 DR_HDR SHALL drive tms = 1,0,0 (Select-DR, Capture-DR, Shift-DR).
REQ-026 DR_SHIFT SHALL last DATA_REG cycles, with tdi = latched DR bit i (LSB first) and tms=0, except tms=1 on the last bit.
REQ-027 DR_TAIL SHALL drive tms = 1,0, then go to DONE.
REQ-028 tdi SHALL be 0 outside shift cycles.
REQ-029 TDO capture: in the cycle after DR shift cycle i (i=0..DATA_REG-1), tdo SHALL be stored into rsp_dr[i]; the final sample falls in the first DR_TAIL cycle.
REQ-030 TDO SHALL be ignored during IR shift.
REQ-031 A shift counter of width clog2(max(IR_WIDTH,DATA_REG))+1 SHALL count from 0 up to length-1, with no wrap beyond that.
REQ-032 DONE SHALL last one cycle with rsp_valid=1, tms=0, then return to IDLE; rsp_dr SHALL hold its value until the next DR capture.
REQ-033 A full scan SHALL take IR_WIDTH+DATA_REG+11 drive cycles; a DR-only scan SHALL take DATA_REG+5.
REQ-034 cmd_valid while busy SHALL be ignored; the command is neither latched nor queued.
REQ-035 Input changes after acceptance SHALL NOT affect the scan in progress.
REQ-036 An unreachable state encoding SHALL go to INIT_TLR.

Reset
REQ-037 On trst=1 at a rising edge: state=INIT_TLR, tms=1, tdi=0, cmd_ready=0, busy=1, rsp_valid=0, rsp_dr=0, counters=0.
REQ-038 Reset mid-scan SHALL abandon the scan with no rsp_valid and SHALL rerun the full init sequence.

Verification
REQ-039 Release reset -> tms=1,1,1,1,1,0 over 6 cycles, then cmd_ready=1 in cycle 7.
REQ-040 Command ir=2'b10, dr=5'b00000, skip_ir=0 -> tms=1,1,0,0,0,1,1,0 then 1,0,0,0,0,0,0,1,1,0, tdi=0,1 in the IR shift cycles, rsp_valid after 18 cycles.
REQ-041 Loopback bench (tdo = tdi delayed 1 cycle), dr=5'b10110, skip_ir=1 -> tdi in DR shift cycles = 0,1,1,0,1; rsp_dr=5'b10110; rsp_valid in cycle 11 after acceptance.
REQ-042 cmd_valid held high through a scan -> exactly one acceptance per IDLE visit, second command starts only after DONE.
REQ-043 trst=1 during DR_SHIFT -> no rsp_valid, rsp_dr=0, tms=1 for 5 cycles then 0, cmd_ready returns.
